// File: rtl/ads1115_pkg.sv
// ads1115_pkg
//   Shared definitions for the ADS1115 I2C responder: register pointer codes,
//   config register reset value and field positions, input mux codes, the bus
//   FSM state type and the conversion result selection helpers.
package ads1115_pkg;

  // Register pointer codes (low two bits of the pointer byte).
  localparam logic [1:0] PTR_CONV      = 2'd0;
  localparam logic [1:0] PTR_CONFIG    = 2'd1;
  localparam logic [1:0] PTR_LO_THRESH = 2'd2;
  localparam logic [1:0] PTR_HI_THRESH = 2'd3;

  // Register reset values.
  localparam logic [15:0] CONFIG_RESET    = 16'h8583;
  localparam logic [15:0] LO_THRESH_RESET = 16'h8000;
  localparam logic [15:0] HI_THRESH_RESET = 16'h7FFF;

  // Config register fields.
  localparam int CFG_OS     = 15;
  localparam int CFG_MUX_HI = 14;
  localparam int CFG_MUX_LO = 12;

  // Input mux codes.
  localparam logic [2:0] MUX_AIN0_AIN1 = 3'b000;
  localparam logic [2:0] MUX_AIN0_AIN3 = 3'b001;
  localparam logic [2:0] MUX_AIN1_AIN3 = 3'b010;
  localparam logic [2:0] MUX_AIN2_AIN3 = 3'b011;
  localparam logic [2:0] MUX_AIN0      = 3'b100;
  localparam logic [2:0] MUX_AIN1      = 3'b101;
  localparam logic [2:0] MUX_AIN2      = 3'b110;
  localparam logic [2:0] MUX_AIN3      = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  // Signed a-b, computed with one guard bit and clamped to the 16-bit range.
  function automatic logic [15:0] sat_diff(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] diff;
    diff = $signed({a[15], a}) - $signed({b[15], b});
    if (diff > 17'sd32767)  return 16'h7FFF;
    if (diff < -17'sd32768) return 16'h8000;
    return diff[15:0];
  endfunction

  // Conversion result for a mux code; AINn occupies ain[16n+15:16n].
  function automatic logic [15:0] conv_result(input logic [2:0] mux, input logic [63:0] ain);
    logic [15:0] ain0, ain1, ain2, ain3;
    ain0 = ain[15:0];
    ain1 = ain[31:16];
    ain2 = ain[47:32];
    ain3 = ain[63:48];
    case (mux)
      MUX_AIN0_AIN1: return sat_diff(ain0, ain1);
      MUX_AIN0_AIN3: return sat_diff(ain0, ain3);
      MUX_AIN1_AIN3: return sat_diff(ain1, ain3);
      MUX_AIN2_AIN3: return sat_diff(ain2, ain3);
      MUX_AIN0:      return ain0;
      MUX_AIN1:      return ain1;
      MUX_AIN2:      return ain2;
      default:       return ain3;
    endcase
  endfunction

endpackage

// File: rtl/ads1115_i2c_responder_sync.sv
// i2c_bus_sync
//   Brings SCL/SDA into the clk domain through 2-flop synchronizers and
//   derives SCL edges plus START/STOP conditions from the synchronized values.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   scl, sda_in           raw bus levels
//   scl_rise, scl_fall    one-clk pulses on synchronized SCL edges
//   sda_s                 synchronized SDA level
//   start_det, stop_det   one-clk pulses: SDA fell / rose while SCL high
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic scl_meta, scl_s, scl_q;
  logic sda_meta, sda_q;

  // Flops reset to 1 so an idle (pulled-up) bus produces no edges on release.
  // NOTE: non-blocking assignments let every stage sample its pre-edge value;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_meta <= 1'b1;
      scl_s    <= 1'b1;
      scl_q    <= 1'b1;
      sda_meta <= 1'b1;
      sda_s    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_s    <= scl_meta;
      scl_q    <= scl_s;
      sda_meta <= sda_in;
      sda_s    <= sda_meta;
      sda_q    <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/ads1115_i2c_responder.sv
// ads1115_i2c_responder
//   I2C target emulating the ADS1115 register map (pointer, config, thresholds,
//   conversion) with a timed single-shot conversion over four input channels.
// Ports:
//   clk, reset    system clock (>= 8x SCL), synchronous active-high reset
//   scl, sda_in   bus levels as seen on the wire
//   sda_oe        1 pulls SDA low (open drain)
//   ain_values    four signed 16-bit channel values, AINn = [16n+15:16n]
//   conv_busy     conversion in progress
//   conv_ready    one-clk pulse when the conversion register updates
module ads1115_i2c_responder
  import ads1115_pkg::*;
#(
  parameter logic [6:0] I2C_ADDRESS = 7'h48,
  parameter int         CONV_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [63:0] ain_values,
  output logic        conv_busy,
  output logic        conv_ready
);

  localparam int CNT_W = $clog2(CONV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_e       state;
  logic [3:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic [15:0]      tx_shift;
  logic             rw;
  logic             byte_sel;   // 0: next byte is MSB, 1: next byte is LSB
  logic [7:0]       wr_msb;
  logic [1:0]       pointer;
  logic [15:0]      config_reg, lo_thresh, hi_thresh, conv_reg;
  logic             conv_start;
  logic [2:0]       conv_mux;
  logic [CNT_W-1:0] conv_cnt;
  logic [15:0]      read_value;

  // Value presented for a read of the pointed register; OS reads as ~busy.
  // NOTE: read_value gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    read_value = conv_reg;
    unique case (pointer)
      PTR_CONV:      read_value = conv_reg;
      PTR_CONFIG:    read_value = {~conv_busy, config_reg[14:0]};
      PTR_LO_THRESH: read_value = lo_thresh;
      PTR_HI_THRESH: read_value = hi_thresh;
      default:       read_value = conv_reg;
    endcase
  end

  // Bus FSM. SDA is sampled on SCL rise; sda_oe only moves on SCL fall
  // (START/STOP force a release regardless).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rw         <= 1'b0;
      byte_sel   <= 1'b0;
      wr_msb     <= '0;
      pointer    <= PTR_CONV;
      config_reg <= CONFIG_RESET;
      lo_thresh  <= LO_THRESH_RESET;
      hi_thresh  <= HI_THRESH_RESET;
      sda_oe     <= 1'b0;
      conv_start <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      if (stop_det || start_det) begin
        state    <= stop_det ? ST_IDLE : ST_ADDR;
        bit_cnt  <= '0;
        byte_sel <= 1'b0;
        sda_oe   <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: ;

          ST_ADDR: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (rx_shift[7:1] == I2C_ADDRESS) begin
                rw     <= rx_shift[0];
                sda_oe <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                // Snapshot the pair and put its first bit on the bus at once.
                tx_shift <= read_value;
                sda_oe   <= ~read_value[15];
                byte_sel <= 1'b0;
                state    <= ST_RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_PTR;
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              pointer <= rx_shift[1:0];
              sda_oe  <= 1'b1;
              state   <= ST_PTR_ACK;
            end
          end

          ST_PTR_ACK: begin
            if (scl_fall) begin
              sda_oe   <= 1'b0;
              byte_sel <= 1'b0;
              state    <= ST_WR_DATA;
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (!byte_sel) wr_msb <= rx_shift;
              sda_oe  <= 1'b1;
              state   <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            // rx_shift still holds the LSB: no shifting happens in this state.
            if (scl_fall) begin
              sda_oe   <= 1'b0;
              byte_sel <= ~byte_sel;
              state    <= ST_WR_DATA;
              if (byte_sel) begin
                unique case (pointer)
                  PTR_CONFIG: begin
                    config_reg <= {wr_msb, rx_shift};
                    conv_start <= wr_msb[CFG_OS-8] & ~conv_busy;
                  end
                  PTR_LO_THRESH: lo_thresh <= {wr_msb, rx_shift};
                  PTR_HI_THRESH: hi_thresh <= {wr_msb, rx_shift};
                  default: ;  // conversion register is read-only
                endcase
              end
            end
          end

          ST_RD_DATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              tx_shift <= {tx_shift[14:0], 1'b0};
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe <= ~tx_shift[14];
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              rx_shift <= {rx_shift[6:0], sda_s};
            end else if (scl_fall) begin
              if (!rx_shift[0]) begin
                state <= ST_RD_DATA;
                if (!byte_sel) begin
                  // After 8 shifts the LSB already sits at the top.
                  byte_sel <= 1'b1;
                  sda_oe   <= ~tx_shift[15];
                end else begin
                  byte_sel <= 1'b0;
                  tx_shift <= read_value;
                  sda_oe   <= ~read_value[15];
                end
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
          end

          ST_IGNORE: sda_oe <= 1'b0;

          default: begin
            sda_oe <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Single-shot conversion: busy for CONV_CYCLES clks, channels sampled on the
  // completion cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      conv_busy  <= 1'b0;
      conv_ready <= 1'b0;
      conv_cnt   <= '0;
      conv_mux   <= '0;
      conv_reg   <= '0;
    end else begin
      conv_ready <= 1'b0;
      if (conv_start) begin
        conv_busy <= 1'b1;
        conv_cnt  <= '0;
        conv_mux  <= config_reg[CFG_MUX_HI:CFG_MUX_LO];
      end else if (conv_busy) begin
        if (conv_cnt == CNT_LAST) begin
          conv_reg   <= conv_result(conv_mux, ain_values);
          conv_ready <= 1'b1;
          conv_busy  <= 1'b0;
        end else begin
          conv_cnt <= conv_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ads1115_i2c_responder.sv
// tb_ads1115_i2c_responder
//   Bus-initiator bench for ads1115_i2c_responder. A register-level model
//   (register array plus conversion start cycle) supplies read expectations;
//   one per-cycle process compares conv_busy/conv_ready with the model and
//   watches that sda_oe never moves while SCL is high.
module tb_ads1115_i2c_responder;

  localparam int         CONV = 1000;
  localparam logic [6:0] ADDR = 7'h48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [63:0] ain = '0;
  logic        sda_oe, conv_busy, conv_ready;
  wire         sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  ads1115_i2c_responder #(.I2C_ADDRESS(ADDR), .CONV_CYCLES(CONV)) dut (
    .clk        (clk),
    .reset      (reset),
    .scl        (scl),
    .sda_in     (sda_bus),
    .sda_oe     (sda_oe),
    .ain_values (ain),
    .conv_busy  (conv_busy),
    .conv_ready (conv_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fall = 0;
  logic oe_seen = 1'b0;
  logic prev_oe = 1'b0;

  // ---------------- model ----------------
  logic [15:0] m_regs [4];
  int          m_start = -100000;
  logic [2:0]  m_mux = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Commit lands 3 clks after SCL is driven low (2 sync flops + edge reg);
  // busy follows one clk later and lasts CONV clks.
  function automatic bit m_busy_at(input int c);
    return (c >= m_start + 4) && (c < m_start + 4 + CONV);
  endfunction

  function automatic logic [15:0] m_result(input logic [2:0] mux, input logic [63:0] a);
    int ch [4];
    int v;
    for (int i = 0; i < 4; i++) ch[i] = int'($signed(a[16*i +: 16]));
    case (mux)
      3'd0: v = ch[0] - ch[1];
      3'd1: v = ch[0] - ch[3];
      3'd2: v = ch[1] - ch[3];
      3'd3: v = ch[2] - ch[3];
      default: v = ch[mux - 3'd4];
    endcase
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] p, input int c);
    if (p == 2'd1) return {~m_busy_at(c), m_regs[1][14:0]};
    return m_regs[p];
  endfunction

  task automatic m_reset();
    m_regs[0] = 16'h0000;
    m_regs[1] = 16'h8583;
    m_regs[2] = 16'h8000;
    m_regs[3] = 16'h7FFF;
    m_start   = -100000;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare process.
  always @(negedge clk) begin
    check("conv_busy", conv_busy, m_busy_at(cyc));
    check("conv_ready", conv_ready, cyc == m_start + 4 + CONV);
    if (cyc == m_start + 4 + CONV) m_regs[0] = m_result(m_mux, ain);
    if (!reset && scl) check("sda_oe_stable_scl_high", sda_oe, prev_oe);
    if (sda_oe) oe_seen = 1'b1;
    prev_oe = sda_oe;
  end

  // ---------------- bus initiator ----------------
  task automatic q();
    repeat (4) @(negedge clk);
  endtask

  task automatic bit_io(input logic b, output logic s);
    q(); m_sda = b;
    q(); scl = 1'b1;
    q(); s = sda_bus;
    q(); scl = 1'b0;
    last_fall = cyc;
  endtask

  task automatic i2c_start();
    q(); m_sda = 1'b1;
    q(); scl = 1'b1;
    q(); m_sda = 1'b0;
    q(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    q(); m_sda = 1'b0;
    q(); scl = 1'b1;
    q(); m_sda = 1'b1;
    q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_io(b[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      b[i] = s;
    end
    bit_io(~ack, s);
  endtask

  task automatic start_addr(input logic rd, input string tag);
    logic ack;
    i2c_start();
    write_byte({ADDR, rd}, ack);
    check({tag, "_addr_ack"}, ack, 1'b1);
  endtask

  task automatic reg_write(input logic [1:0] p, input logic [15:0] d, input bit full,
                           input string tag);
    logic ack;
    start_addr(1'b0, tag);
    write_byte({6'd0, p}, ack);  check({tag, "_ptr_ack"}, ack, 1'b1);
    write_byte(d[15:8], ack);    check({tag, "_msb_ack"}, ack, 1'b1);
    if (full) begin
      write_byte(d[7:0], ack);   check({tag, "_lsb_ack"}, ack, 1'b1);
      if (p == 2'd1 && d[15] && !m_busy_at(last_fall + 3)) begin
        m_start = last_fall;
        m_mux   = d[14:12];
      end
      if (p != 2'd0) m_regs[p] = d;
    end
    i2c_stop();
  endtask

  task automatic reg_read(input logic [1:0] p, output logic [15:0] d, input string tag);
    logic        ack;
    logic [15:0] exp;
    start_addr(1'b0, tag);
    write_byte({6'd0, p}, ack);  check({tag, "_ptr_ack"}, ack, 1'b1);
    i2c_start();
    write_byte({ADDR, 1'b1}, ack);
    check({tag, "_raddr_ack"}, ack, 1'b1);
    exp = m_read(p, last_fall + 3);
    read_byte(1'b1, d[15:8]);
    read_byte(1'b0, d[7:0]);
    i2c_stop();
    check({tag, "_model"}, d, exp);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!conv_ready && n < 3 * CONV) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_in_time"}, n < 3 * CONV, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] d;
    logic [7:0]  b0, b1, b2, b3;
    logic        ack, s;

    m_reset();
    repeat (5) @(negedge clk);
    reset = 1'b0;
    q();
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", conv_busy, 1'b0);
    reg_read(2'd0, d, "rst_conv"); check("rst_conv_lit", d, 16'h0000);
    reg_read(2'd1, d, "rst_cfg");  check("rst_cfg_lit", d, 16'h8583);
    reg_read(2'd2, d, "rst_lo");   check("rst_lo_lit", d, 16'h8000);
    reg_read(2'd3, d, "rst_hi");   check("rst_hi_lit", d, 16'h7FFF);

    // Single-ended AIN0 conversion.
    ain = {16'h0000, 16'h0000, 16'h0000, 16'h3A98};
    reg_write(2'd1, 16'hC383, 1'b1, "t1_wr");
    reg_read(2'd1, d, "t1_cfg_busy"); check("t1_cfg_busy_lit", d, 16'h4383);
    wait_ready("t1");
    reg_read(2'd0, d, "t1_conv"); check("t1_conv_lit", d, 16'h3A98);

    // Conversion register is read-only.
    reg_write(2'd0, 16'h1111, 1'b1, "ro_wr");
    reg_read(2'd0, d, "ro_conv"); check("ro_conv_lit", d, 16'h3A98);

    // Wrong address: never ACKed, SDA never pulled.
    oe_seen = 1'b0;
    i2c_start();
    write_byte({7'h49, 1'b0}, ack); check("bad_addr_nack", ack, 1'b0);
    write_byte(8'h01, ack);         check("bad_addr_data_nack", ack, 1'b0);
    i2c_stop();
    check("bad_addr_oe_never", oe_seen, 1'b0);

    // Differential saturation both ways.
    ain = {16'h0000, 16'h0000, 16'h9000, 16'h7000};
    reg_write(2'd1, 16'h8583, 1'b1, "t3a_wr");
    wait_ready("t3a");
    reg_read(2'd0, d, "t3a_conv"); check("t3a_sat_pos", d, 16'h7FFF);
    ain = {16'h0000, 16'h0000, 16'h7000, 16'h9000};
    reg_write(2'd1, 16'h8583, 1'b1, "t3b_wr");
    wait_ready("t3b");
    reg_read(2'd0, d, "t3b_conv"); check("t3b_sat_neg", d, 16'h8000);

    // Lone MSB discarded, full pair committed.
    reg_write(2'd2, 16'hAB00, 1'b0, "t4_half");
    reg_read(2'd2, d, "t4_lo_kept"); check("t4_lo_kept_lit", d, 16'h8000);
    reg_write(2'd2, 16'h1234, 1'b1, "t4_full");
    reg_read(2'd2, d, "t4_lo_new"); check("t4_lo_new_lit", d, 16'h1234);

    // Repeated START, multi-pair read, NACK releases the bus.
    start_addr(1'b0, "t5");
    write_byte(8'h03, ack); check("t5_ptr_ack", ack, 1'b1);
    i2c_start();
    write_byte({ADDR, 1'b1}, ack); check("t5_raddr_ack", ack, 1'b1);
    read_byte(1'b1, b0);
    read_byte(1'b1, b1);
    read_byte(1'b1, b2);
    read_byte(1'b0, b3);
    check("t5_b0", b0, 8'h7F);
    check("t5_b1", b1, 8'hFF);
    check("t5_b2", b2, 8'h7F);
    check("t5_b3", b3, 8'hFF);
    q();
    check("t5_released", sda_oe, 1'b0);
    bit_io(1'b1, s);
    check("t5_ignore_bit", s, 1'b1);
    i2c_stop();

    // Reset during a driven 0 bit of a config read (reads 8483: MSB 1000_0100).
    reg_write(2'd1, 16'h0483, 1'b1, "t6_wr");
    start_addr(1'b0, "t6");
    write_byte(8'h01, ack); check("t6_ptr_ack", ack, 1'b1);
    i2c_start();
    write_byte({ADDR, 1'b1}, ack); check("t6_raddr_ack", ack, 1'b1);
    bit_io(1'b1, s); check("t6_bit7", s, 1'b1);
    q(); m_sda = 1'b1;
    q(); scl = 1'b1;
    q(); check("t6_zero_bit_driven", sda_bus, 1'b0);
    reset = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    check("t6_oe_after_reset", sda_oe, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q();
    reg_read(2'd1, d, "t6_cfg"); check("t6_cfg_lit", d, 16'h8583);
    reg_read(2'd2, d, "t6_lo");  check("t6_lo_lit", d, 16'h8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=90000", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ads1115_i2c_responder.md
Name: ads1115_i2c_responder

Overview:
- Synthesizable I2C target that emulates the ADS1115 register map at 7-bit address I2C_ADDRESS.
- Serves as the far end of the photodiode ADC I2C link: a bench and FPGA loopback model for the initiator-side ADC interface.
- Oversamples SCL/SDA on the system clock.
- Holds the pointer, config and threshold registers, and runs a timed single-shot conversion on per-channel input values.

Parameters:
- I2C_ADDRESS, 7'h48, responder address.
- CONV_CYCLES, 1000, clk cycles from conversion start to result valid.

Ports:
- clk  input  1  system clock, at least 8x SCL rate.
- reset  input  1  synchronous, active-high.
- scl  input  1  I2C clock, as seen on the bus.
- sda_in  input  1  I2C data, as seen on the bus.
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
- ain_values  input  64  four signed 16-bit channel values; AINn = [16n+15:16n].
- conv_busy  output  1  conversion in progress.
- conv_ready  output  1  one-cycle pulse when the conversion register updates.

Behaviour:
- Input conditioning: scl and sda_in each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- Reset values:
  - sda_oe=0, conv_busy=0, conv_ready=0, state IDLE.
  - pointer=0, config=16'h8583, lo_thresh=16'h8000, hi_thresh=16'h7FFF, conv_reg=0, bit counter=0.
- Bit timing:
  - Sample SDA on the SCL rising edge, MSB first.
  - Change sda_oe only on the SCL falling edge. Never change it while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - IDLE: START goes to ADDR.
  - ADDR: after 8 bits, if addr==I2C_ADDRESS, drive ACK in ADDR_ACK. Then R/W=0 goes to PTR; R/W=1 goes to RD_DATA. On address mismatch, no ACK and go to IGNORE.
  - PTR: the received byte's bits[1:0] become pointer; upper bits are ignored. Always ACK, then go to WR_DATA.
  - WR_DATA/WR_ACK: every byte is ACKed. Bytes alternate MSB then LSB.
    - The target register updates only after the LSB ACK completes. A lone MSB is discarded.
    - Pointer 0 (conversion) is read-only: data is ACKed and dropped.
    - Bytes past LSB start a new MSB/LSB pair to the same pointer.
  - RD_DATA/RD_ACK: shift out the MSB then the LSB of the pointed register.
    - The register value is snapshotted at the start of the MSB.
    - Initiator ACK (SDA low) continues, alternating MSB/LSB and re-snapshotting each pair.
    - Initiator NACK goes to IGNORE.
    - A 0 bit means sda_oe=1.
  - IGNORE: sda_oe=0 until STOP or START.
  - Any state: STOP goes to IDLE. START (repeated) goes to ADDR. In both cases a partial byte or pair is discarded, sda_oe=0 on the next clk, and pointer is retained.
- Config register:
  - Read bit15 = ~conv_busy. Bits[14:0] read as last written.
  - A write with bit15=1 while not busy starts a conversion one clk after commit: conv_busy=1, mux[14:12] latched, counter cleared.
  - A write with bit15=1 while busy updates the config but does not restart the conversion.
- Conversion:
  - After CONV_CYCLES clks, conv_reg is loaded, conv_ready pulses for 1 clk, and conv_busy=0.
  - Result selection by mux:
    - 100..111: AIN0..AIN3.
    - 000: AIN0-AIN1. 001: AIN0-AIN3. 010: AIN1-AIN3. 011: AIN2-AIN3.
    - Differences use a 17-bit signed subtract, saturated to 16'h7FFF / 16'h8000.
  - Channel values are sampled on the completion cycle.
- A read of conv_reg during a conversion returns the previous result.
- Reset mid-transaction or mid-conversion: everything returns to the reset values on the next clk.

Decomposition:
- Shared package ads1115_pkg:
  - Register pointer constants: CONV=0, CONFIG=1, LO_THRESH=2, HI_THRESH=3.
  - Config reset value and bitfield positions (OS=15, MUX=14:12).
  - State enum.
  - MUX code constants.
- One natural sub-module: i2c_bus_sync. It holds the 2-flop synchronizers plus edge, START and STOP detection, and outputs scl_rise, scl_fall, sda_s, start_det and stop_det.

Test Plan:
- Write ptr=1, then 16'hC383 (mux=100, OS=1). Expect:
  - ACK on all 4 bytes.
  - conv_busy=1 one clk after commit.
  - Config read during the conversion returns 16'h4383.
  - conv_ready after CONV_CYCLES, with AIN0=16'h3A98, then a conv_reg read returns 16'h3A98.
- Address 7'h49 with a write. Expect SDA never pulled low (NACK). The following START to 7'h48 is ACKed normally.
- Differential saturation: mux=000 with AIN0=16'h7000, AIN1=16'h9000. Expect conv_reg=16'h7FFF. Swapping the two values gives 16'h8000.
- Write ptr=2 with MSB only, then STOP. Expect lo_thresh to still read 16'h8000. A full write of 16'h1234 then reads back 16'h1234.
- Repeated START: write ptr=3, then Sr plus read with ACK,ACK,ACK,NACK. Expect the bytes 7F,FF,7F,FF, then SDA released.
- Assert reset mid-read, during a 0 bit. Expect sda_oe=0 on the next clk and config to read 16'h8583 afterwards.
